// File: rtl/req_parse.sv
// req_parse: three-chunk read-request parser with framing-error and overrun counters.
// Optional inter-chunk idle timeout is enabled by defining REQ_PARSE_TIMEOUT_EN.
module req_parse #(
  parameter int DATA_WIDTH     = 64,
  parameter int IPG_WIDTH      = 56,
  parameter int PORT_WIDTH     = 12,
  parameter int REQL_WIDTH     = 8,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   ipg_req_chunk,
  input  logic                    valid_req,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic [REQL_WIDTH-1:0]   req_len,
  output logic [PORT_WIDTH/2-1:0] req_src_port,
  output logic [PORT_WIDTH/2-1:0] req_dst_port,
  output logic [IPG_WIDTH-1:0]    req_src_addr,
  output logic [IPG_WIDTH-1:0]    req_dst_addr,
  output logic [CNT_WIDTH-1:0]    err_count,
  output logic [CNT_WIDTH-1:0]    drop_count
);

  localparam int HP = PORT_WIDTH / 2;
  localparam logic [7:0] TAG_HDR  = 8'h0a;
  localparam logic [7:0] TAG_BLK1 = 8'h1a;
  localparam logic [7:0] TAG_BLK2 = 8'h2a;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_SRC
  } state_t;

  typedef struct packed {
    logic [REQL_WIDTH-1:0] len;
    logic [HP-1:0]         src_port;
    logic [HP-1:0]         dst_port;
    logic [IPG_WIDTH-1:0]  src_addr;
    logic [IPG_WIDTH-1:0]  dst_addr;
  } req_t;

  state_t state, state_nxt;
  req_t   part_q;
  req_t   out_q;
  logic   vld_q;

  logic is_hdr, is_blk1, is_blk2;
  logic hdr_ld, src_ld, done, frame_err;
  logic tmo, err_inc, load, drop;

  logic [REQL_WIDTH-1:0] c_len;
  logic [PORT_WIDTH-1:0] c_port;
  logic [IPG_WIDTH-1:0]  c_addr;

  assign is_hdr  = ipg_req_chunk[7:0] == TAG_HDR;
  assign is_blk1 = ipg_req_chunk[7:0] == TAG_BLK1;
  assign is_blk2 = ipg_req_chunk[7:0] == TAG_BLK2;

  assign c_len  = ipg_req_chunk[DATA_WIDTH-1 -: REQL_WIDTH];
  assign c_port = ipg_req_chunk[DATA_WIDTH-REQL_WIDTH-1 -: PORT_WIDTH];
  assign c_addr = ipg_req_chunk[8 +: IPG_WIDTH];

`ifdef REQ_PARSE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Fires on the idle cycle that would bring the count to TIMEOUT_CYCLES.
  assign tmo = (state != S_IDLE) && !valid_req &&
               (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == S_IDLE || valid_req || tmo) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    hdr_ld    = 1'b0;
    src_ld    = 1'b0;
    done      = 1'b0;
    frame_err = 1'b0;
    if (valid_req) begin
      unique case (state)
        S_IDLE: begin
          if (is_hdr) begin
            hdr_ld    = 1'b1;
            state_nxt = S_HDR;
          end else begin
            frame_err = 1'b1;
          end
        end
        S_HDR: begin
          unique case (1'b1)
            is_blk1: begin
              src_ld    = 1'b1;
              state_nxt = S_SRC;
            end
            is_hdr: begin
              frame_err = 1'b1;
              hdr_ld    = 1'b1;
            end
            default: begin
              frame_err = 1'b1;
              state_nxt = S_IDLE;
            end
          endcase
        end
        S_SRC: begin
          unique case (1'b1)
            is_blk2: begin
              done      = 1'b1;
              state_nxt = S_IDLE;
            end
            is_hdr: begin
              frame_err = 1'b1;
              hdr_ld    = 1'b1;
              state_nxt = S_HDR;
            end
            default: begin
              frame_err = 1'b1;
              state_nxt = S_IDLE;
            end
          endcase
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (tmo) begin
      state_nxt = S_IDLE;
    end
  end

  assign err_inc = frame_err | tmo;
  assign load    = done && (!vld_q || req_ready);
  assign drop    = done && !load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      part_q <= '0;
    end else begin
      if (hdr_ld) begin
        part_q.len      <= c_len;
        part_q.src_port <= c_port[PORT_WIDTH-1 -: HP];
        part_q.dst_port <= c_port[HP-1:0];
      end
      if (src_ld) begin
        part_q.src_addr <= c_addr;
      end
    end
  end

  // Output holding register; a completion may reload it in the accept cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else if (load) begin
      out_q.len      <= part_q.len;
      out_q.src_port <= part_q.src_port;
      out_q.dst_port <= part_q.dst_port;
      out_q.src_addr <= part_q.src_addr;
      out_q.dst_addr <= c_addr;
      vld_q          <= 1'b1;
    end else if (req_ready) begin
      vld_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_inc && err_count != '1) begin
      err_count <= err_count + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (drop && drop_count != '1) begin
      drop_count <= drop_count + CNT_WIDTH'(1);
    end
  end

  assign req_valid    = vld_q;
  assign req_len      = out_q.len;
  assign req_src_port = out_q.src_port;
  assign req_dst_port = out_q.dst_port;
  assign req_src_addr = out_q.src_addr;
  assign req_dst_addr = out_q.dst_addr;

endmodule

// File: tb/tb_req_parse.sv
// tb_req_parse: directed and random checks of req_parse
// against a queue-based request reassembly model.
module tb_req_parse;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] chunk = '0;
  logic        vld = 1'b0;
  logic        rdy = 1'b0;
  logic        req_valid;
  logic [7:0]  req_len;
  logic [5:0]  req_src_port, req_dst_port;
  logic [55:0] req_src_addr, req_dst_addr;
  logic [15:0] err_count, drop_count;

  req_parse dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ipg_req_chunk(chunk),
    .valid_req    (vld),
    .req_valid    (req_valid),
    .req_ready    (rdy),
    .req_len      (req_len),
    .req_src_port (req_src_port),
    .req_dst_port (req_dst_port),
    .req_src_addr (req_src_addr),
    .req_dst_addr (req_dst_addr),
    .err_count    (err_count),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  len;
    logic [5:0]  sp;
    logic [5:0]  dp;
    logic [55:0] sa;
    logic [55:0] da;
  } req_t;

  int checks = 0;
  int errors = 0;

  logic [63:0] part[$];
  req_t        m_out;
  logic        m_vld;
  int          m_err, m_drop, m_idle;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] hdr(logic [7:0] len, logic [11:0] port);
    return {len, port, 36'h0, 8'h0a};
  endfunction

  function automatic logic [63:0] b1(logic [55:0] a);
    return {a, 8'h1a};
  endfunction

  function automatic logic [63:0] b2(logic [55:0] a);
    return {a, 8'h2a};
  endfunction

  task automatic model_reset();
    part.delete();
    m_out  = '0;
    m_vld  = 1'b0;
    m_err  = 0;
    m_drop = 0;
    m_idle = 0;
  endtask

  task automatic bump_err();
    if (m_err < 65535) m_err++;
  endtask

  // A request is header, BLK1, BLK2 in order; anything out of
  // order is an error, and a stray header starts a new request.
  task automatic model_step(logic v, logic [63:0] c, logic r);
    bit   done;
    req_t n;
    done = 0;
    n    = '0;
    if (v) begin
      m_idle = 0;
      if (c[7:0] == 8'h0a) begin
        if (part.size() != 0) bump_err();
        part.delete();
        part.push_back(c);
      end else if (c[7:0] == 8'h1a && part.size() == 1) begin
        part.push_back(c);
      end else if (c[7:0] == 8'h2a && part.size() == 2) begin
        n.len = part[0][63:56];
        n.sp  = part[0][55:50];
        n.dp  = part[0][49:44];
        n.sa  = part[1][63:8];
        n.da  = c[63:8];
        done  = 1;
        part.delete();
      end else begin
        bump_err();
        part.delete();
      end
    end else if (part.size() != 0) begin
`ifdef REQ_PARSE_TIMEOUT_EN
      m_idle++;
      if (m_idle == 16) begin
        bump_err();
        part.delete();
        m_idle = 0;
      end
`endif
    end
    if (done) begin
      if (!m_vld || r) begin
        m_out = n;
        m_vld = 1'b1;
      end else if (m_drop < 65535) begin
        m_drop++;
      end
    end else if (m_vld && r) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic compare(string t);
    check({t, ":vld"}, 64'(req_valid), 64'(m_vld));
    check({t, ":len"}, 64'(req_len), 64'(m_out.len));
    check({t, ":sp"}, 64'(req_src_port), 64'(m_out.sp));
    check({t, ":dp"}, 64'(req_dst_port), 64'(m_out.dp));
    check({t, ":sa"}, 64'(req_src_addr), 64'(m_out.sa));
    check({t, ":da"}, 64'(req_dst_addr), 64'(m_out.da));
    check({t, ":err"}, 64'(err_count), 64'(m_err));
    check({t, ":drop"}, 64'(drop_count), 64'(m_drop));
  endtask

  task automatic cyc(string t, logic v, logic [63:0] c, logic r);
    @(negedge clk);
    vld   = v;
    chunk = c;
    rdy   = r;
    @(posedge clk);
    #1;
    model_step(v, c, r);
    compare(t);
  endtask

  task automatic do_reset();
    @(negedge clk);
    vld   = 1'b0;
    rdy   = 1'b0;
    chunk = '0;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic        rv, rr;
  logic [63:0] rc;
  logic [7:0]  rtag;
  int          nxt, k;

  initial begin
    model_reset();
    do_reset();

    // Back-to-back request, ready held high
    cyc("t1", 1, hdr(8'hA0, 12'h041), 1);
    cyc("t1", 1, b1(56'h1234), 1);
    cyc("t1", 1, b2(56'h1234), 1);
    check("t1_vld", 64'(req_valid), 64'd1);
    check("t1_len", 64'(req_len), 64'hA0);
    check("t1_sp", 64'(req_src_port), 64'd1);
    check("t1_dp", 64'(req_dst_port), 64'd1);
    check("t1_sa", 64'(req_src_addr), 64'h1234);
    cyc("t1", 0, '0, 1);
    check("t1_fall", 64'(req_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc("t1b", 1, hdr(8'(i), 12'h3c5), 1);
      cyc("t1b", 1, b1(56'(i + 7)), 1);
      cyc("t1b", 1, b2(56'(i + 9)), 1);
    end
    check("t1_nodrop", 64'(drop_count), 64'd0);
    check("t1_noerr", 64'(err_count), 64'd0);

    // Overrun: ten requests with ready low
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc("t2", 1, hdr(8'(8'h10 + i), 12'hfff), 0);
      cyc("t2", 1, b1(56'(i)), 0);
      cyc("t2", 1, b2(56'(i + 100)), 0);
    end
    check("t2_drop", 64'(drop_count), 64'd9);
    check("t2_len", 64'(req_len), 64'h10);
    check("t2_da", 64'(req_dst_addr), 64'd100);
    cyc("t2", 0, '0, 1);
    check("t2_fall", 64'(req_valid), 64'd0);

    // Header then BLK2, then a full request
    do_reset();
    cyc("t3", 1, hdr(8'h11, 12'h0ff), 1);
    cyc("t3", 1, b2(56'h55), 1);
    cyc("t3", 1, hdr(8'h22, 12'h123), 1);
    cyc("t3", 1, b1(56'habc), 1);
    cyc("t3", 1, b2(56'hdef), 1);
    check("t3_err", 64'(err_count), 64'd1);
    check("t3_len", 64'(req_len), 64'h22);
    check("t3_vld", 64'(req_valid), 64'd1);

    // Resync on second header
    do_reset();
    cyc("t4", 1, hdr(8'd5, 12'h001), 0);
    cyc("t4", 1, b1(56'h1), 0);
    cyc("t4", 1, hdr(8'd7, 12'h002), 0);
    cyc("t4", 1, b1(56'h2), 0);
    cyc("t4", 1, b2(56'h3), 0);
    check("t4_err", 64'(err_count), 64'd1);
    check("t4_len", 64'(req_len), 64'd7);

    // Async reset after BLK1 with a held output
    do_reset();
    cyc("t5", 1, hdr(8'h33, 12'h555), 0);
    cyc("t5", 1, b1(56'h77), 0);
    cyc("t5", 1, b2(56'h88), 0);
    cyc("t5", 1, hdr(8'h44, 12'h666), 0);
    cyc("t5", 1, b1(56'h99), 0);
    #2;
    vld   = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare("t5_arst");
    check("t5_vld", 64'(req_valid), 64'd0);
    check("t5_len", 64'(req_len), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("t5", 1, b2(56'haa), 1);
    check("t5_nopart", 64'(req_valid), 64'd0);
    cyc("t5", 1, hdr(8'h66, 12'h7c1), 1);
    cyc("t5", 1, b1(56'hbb), 1);
    cyc("t5", 1, b2(56'hcc), 1);
    check("t5_len2", 64'(req_len), 64'h66);

`ifdef REQ_PARSE_TIMEOUT_EN
    do_reset();
    cyc("t6", 1, hdr(8'h01, 12'h0c3), 0);
    repeat (16) cyc("t6", 0, '0, 0);
    check("t6_err", 64'(err_count), 64'd1);
    cyc("t6", 1, b1(56'h5), 0);
    check("t6_late", 64'(err_count), 64'd2);
    do_reset();
    cyc("t7", 1, hdr(8'h02, 12'h0c3), 0);
    repeat (15) cyc("t7", 0, '0, 0);
    cyc("t7", 1, b1(56'h6), 0);
    cyc("t7", 1, b2(56'h7), 0);
    check("t7_vld", 64'(req_valid), 64'd1);
    check("t7_err", 64'(err_count), 64'd0);
`endif

    // Random mostly well-formed stream with random ready
    do_reset();
    nxt = 0;
    for (int i = 0; i < 3000; i++) begin
      rv = ($urandom_range(9) < 7);
      rr = 1'($urandom_range(1));
      rc = {$urandom, $urandom};
      k  = $urandom_range(19);
      if (k < 18)
        rtag = (nxt == 0) ? 8'h0a : (nxt == 1) ? 8'h1a : 8'h2a;
      else if (k == 18)
        rtag = 8'h2a;
      else
        rtag = 8'(8'h30 + $urandom_range(15));
      rc[7:0] = rtag;
      if (rv) begin
        if (rtag == 8'h0a) nxt = 1;
        else if (rtag == 8'h1a && nxt == 1) nxt = 2;
        else nxt = 0;
      end
      cyc("rnd", rv, rc, rr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
